macc_dot_sequencer: RTL and testbench
=====================================

// Module: macc_dot_sequencer
// PURPOSE
//  Sequences one 7-series pre-add/multiply/accumulate DSP macro through an N-tap dot product.
//  Issues operand-memory addresses and aligns MACC LOAD/CE/zero-gating with operand arrival.
//  Waits out the macro latency, then captures the accumulated result and holds it under a
//  valid/ready handshake. Sits between the job source and the MACC plus its operand RAMs.
// PARAMETERS
//  ADDR_W         6   operand memory address width; max taps = 2**ADDR_W
//  MEM_LAT        1   operand RAM read latency in cycles, 1-3
//  LATENCY        4   MACC macro latency, 1-4 (must match the instantiated macro)
//  WIDTH_PRODUCT  48  MACC accumulator/result width, 1-48
// PORTS
//  CLK            in   1              clock, all logic rising-edge
//  RST_N          in   1              asynchronous active-low reset
//  START          in   1              job request; sampled only in IDLE
//  LEN            in   ADDR_W         taps-1, sampled with START
//  BIAS           in   WIDTH_PRODUCT  accumulator seed, sampled with START
//  ABORT          in   1              cancel current job, any state
//  BUSY           out  1              job in ISSUE/DRAIN/DONE
//  ADDR           out  ADDR_W         operand RAM read address
//  MAC_CE         out  1              MACC clock enable
//  MAC_LOAD       out  1              MACC accumulator load (first tap)
//  MAC_LOAD_DATA  out  WIDTH_PRODUCT  MACC load value (= registered BIAS)
//  MAC_ZERO       out  1              datapath forces MULTIPLIER to 0 when high
//  MAC_PRODUCT    in   WIDTH_PRODUCT  MACC PRODUCT output
//  RESULT         out  WIDTH_PRODUCT  captured dot product
//  RESULT_VALID   out  1              RESULT valid
//  RESULT_READY   in   1              consumer accepts RESULT
// BEHAVIOUR
//  Reset: state IDLE; every output 0; LEN/BIAS registers 0.
//  MACC model: on each CE cycle, acc = (LOAD ? LOAD_DATA : acc) + (PREADD1+PREADD2)*MULT.
//   The result appears on MAC_PRODUCT LATENCY cycles after that cycle.
//  FSM: IDLE -> ISSUE on START & !ABORT. ISSUE -> DRAIN after ADDR=LEN is issued.
//   DRAIN -> DONE at the capture cycle. DONE -> IDLE on RESULT_READY.
//  Timing, START sampled in cycle S:
//   ISSUE occupies cycles S+1 .. S+1+LEN; ADDR = 0..LEN, one per cycle, ADDR=0 outside ISSUE.
//   Operand k reaches the MACC in cycle S+1+k+MEM_LAT. MAC_ZERO=0 exactly in those cycles.
//   MAC_ZERO=1 in every other cycle while MAC_CE=1.
//   MAC_LOAD=1 only in cycle S+1+MEM_LAT (tap 0); MAC_LOAD_DATA=BIAS while BUSY, else 0.
//   MAC_CE=1 from cycle S+1 through capture cycle C = S+1+LEN+MEM_LAT+LATENCY, else 0.
//   RESULT <= MAC_PRODUCT at end of cycle C; RESULT_VALID=1 from C+1 until the handshake.
//  Implementation: delay line of depth MEM_LAT carries {valid,first} from ISSUE to MAC_ZERO/MAC_LOAD.
//   A down-counter of MEM_LAT+LATENCY times DRAIN.
//  Handshake: RESULT and RESULT_VALID stable while VALID & !READY. Transfer on VALID&READY.
//   RESULT_VALID drops the next cycle. RESULT keeps its last value.
//  START outside IDLE is ignored (no queueing). START in the handshake cycle is also ignored.
//  ABORT (priority over everything): next cycle IDLE, MAC_CE/MAC_LOAD/RESULT_VALID=0, delay line cleared.
//   RESULT is retained. ABORT & START in IDLE: stay IDLE.
//  LEN=0: single tap; tap 0 carries both MAC_LOAD=1 and MAC_ZERO=0.
//  LEN=2**ADDR_W-1: ADDR reaches all-ones, no wrap, no extra cycle.
//  RST_N low mid-job: immediate return to reset values, regardless of state.
// TESTING
//  Reset: RST_N=0 mid-ISSUE -> all outputs 0 immediately; after release, IDLE and BUSY=0.
//  Defaults, LEN=3, BIAS=10, data {1,2,3,4}, coef 1, START at cycle 0
//   -> ADDR 0..3 in cycles 1-4, MAC_LOAD at cycle 2, VALID from cycle 10, RESULT=20.
//  LEN=0, BIAS=0, data 7, coef 3 -> MAC_LOAD and !MAC_ZERO same cycle, RESULT=21, VALID at cycle 7.
//  Backpressure: RESULT_READY low 5 cycles -> RESULT/VALID stable; READY -> VALID=0 next cycle, IDLE.
//   Second START then gives a correct new result (no leftover accumulation).
//  ABORT at cycle 3 of the LEN=3 job -> cycle 4 IDLE, MAC_CE=0, no RESULT_VALID.
//   Next job gives its correct sum.
//  START pulsed during ISSUE/DONE -> ignored; LEN=63 -> ADDR 0..63, VALID at cycle 70.

Source files
------------

// File: rtl/macc_dot_sequencer.sv
// -----------------------------------------------------------------------------
// macc_dot_sequencer
//
// Sequences a pre-add/multiply/accumulate DSP macro through an N-tap dot
// product. Walks the operand RAM address from 0 to len, lines up the MACC
// load/zero-gating with the operand RAM read latency, waits out the macro
// latency and then captures the accumulated product, holding it under a
// valid/ready handshake.
//
// Ports
//   clk            clock, everything on the rising edge
//   rst_n          asynchronous active-low reset
//   start          job request, sampled only while idle
//   len            taps-1, captured with start
//   bias           accumulator seed, captured with start
//   abort          cancel the current job from any state
//   busy           a job is issuing, draining or waiting on the handshake
//   addr           operand RAM read address (0 outside the issue phase)
//   mac_ce         MACC clock enable
//   mac_load       MACC accumulator load, asserted on tap 0 only
//   mac_load_data  MACC load value (captured bias while busy)
//   mac_zero       forces the MACC multiplier input to zero
//   mac_product    MACC accumulator output
//   result         captured dot product, kept after the handshake
//   result_valid   result is valid
//   result_ready   consumer accepts result
// -----------------------------------------------------------------------------
module macc_dot_sequencer #(
  parameter int ADDR_W        = 6,
  parameter int MEM_LAT       = 1,
  parameter int LATENCY       = 4,
  parameter int WIDTH_PRODUCT = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        len,
  input  logic [WIDTH_PRODUCT-1:0] bias,
  input  logic                     abort,
  output logic                     busy,
  output logic [ADDR_W-1:0]        addr,
  output logic                     mac_ce,
  output logic                     mac_load,
  output logic [WIDTH_PRODUCT-1:0] mac_load_data,
  output logic                     mac_zero,
  input  logic [WIDTH_PRODUCT-1:0] mac_product,
  output logic [WIDTH_PRODUCT-1:0] result,
  output logic                     result_valid,
  input  logic                     result_ready
);

  // The drain phase covers the operand RAM latency plus the MACC latency, so
  // the last tap has both arrived and propagated to mac_product at capture.
  localparam int DRAIN_CYC = MEM_LAT + LATENCY;
  localparam int CW        = $clog2(DRAIN_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        len_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [WIDTH_PRODUCT-1:0] bias_q;
  logic [CW-1:0]            drain_q;
  logic [MEM_LAT-1:0]       dl_valid_q;
  logic [MEM_LAT-1:0]       dl_first_q;
  logic [WIDTH_PRODUCT-1:0] result_q;

  logic last_tap;
  logic capture;

  assign last_tap = (state_q == ISSUE) && (addr_q == len_q);
  assign capture  = (state_q == DRAIN) && (drain_q == '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)        state_d = ISSUE;
      ISSUE:   if (last_tap)     state_d = DRAIN;
      DRAIN:   if (capture)      state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath: job registers, address counter, drain timer, tap delay line
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      bias_q     <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      dl_valid_q <= '0;
      dl_first_q <= '0;
      result_q   <= '0;
    end else if (abort) begin
      // Job registers and the last result are kept; in-flight taps are dropped.
      addr_q     <= '0;
      drain_q    <= '0;
      dl_valid_q <= '0;
      dl_first_q <= '0;
    end else begin
      // The delay line mirrors the operand RAM latency, so its tail marks the
      // cycle each issued tap's operands are actually at the MACC inputs.
      for (int i = 1; i < MEM_LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_first_q[i] <= dl_first_q[i-1];
      end
      dl_valid_q[0] <= (state_q == ISSUE);
      dl_first_q[0] <= (state_q == ISSUE) && (addr_q == '0);

      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            bias_q <= bias;
            addr_q <= '0;
          end
        end
        ISSUE: begin
          // Stop at len rather than wrapping, so a full-depth job ends on
          // all-ones without an extra cycle.
          if (last_tap) begin
            addr_q  <= '0;
            drain_q <= CW'(DRAIN_CYC - 1);
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (capture) result_q <= mac_product;
          else         drain_q  <= drain_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (state_q != IDLE);
    addr          = addr_q;
    mac_ce        = (state_q == ISSUE) || (state_q == DRAIN);
    mac_load      = mac_ce && dl_first_q[MEM_LAT-1];
    mac_zero      = mac_ce && !dl_valid_q[MEM_LAT-1];
    mac_load_data = busy ? bias_q : '0;
    result        = result_q;
    result_valid  = (state_q == DONE);
  end

endmodule

// File: tb/tb_macc_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_macc_dot_sequencer
//
// Drives dot-product jobs into macc_dot_sequencer, surrounded by a simple
// operand RAM and MACC environment. Expected dot products come from a plain
// bias + sum(data*coef) reference and are queued when a job is issued; a
// monitor pops and compares whenever a result is transferred. A per-cycle
// checker compares the control outputs against the job timeline.
// -----------------------------------------------------------------------------
module tb_macc_dot_sequencer;

  localparam int ADDR_W  = 6;
  localparam int MEM_LAT = 1;
  localparam int LATENCY = 4;
  localparam int W       = 48;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic [W-1:0]      bias = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              mac_ce;
  logic              mac_load;
  logic [W-1:0]      mac_load_data;
  logic              mac_zero;
  logic [W-1:0]      mac_product;
  logic [W-1:0]      result;
  logic              result_valid;
  logic              result_ready = 1'b0;

  macc_dot_sequencer #(
    .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .LATENCY(LATENCY), .WIDTH_PRODUCT(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .abort(abort), .busy(busy), .addr(addr), .mac_ce(mac_ce),
    .mac_load(mac_load), .mac_load_data(mac_load_data), .mac_zero(mac_zero),
    .mac_product(mac_product), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Environment: operand RAMs with MEM_LAT read latency, MACC with LATENCY
  // ---------------------------------------------------------------------------
  logic [15:0] data_mem [DEPTH];
  logic [15:0] coef_mem [DEPTH];
  logic [15:0] rd_a [MEM_LAT];
  logic [15:0] rd_c [MEM_LAT];
  logic [W-1:0] acc_pipe [LATENCY];

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      rd_a[i] <= rd_a[i-1];
      rd_c[i] <= rd_c[i-1];
    end
    rd_a[0] <= data_mem[addr];
    rd_c[0] <= coef_mem[addr];
    if (mac_ce) begin
      acc_pipe[0] <= (mac_load ? mac_load_data : acc_pipe[0]) +
                     (mac_zero ? W'(0) : W'(rd_a[MEM_LAT-1]) * W'(rd_c[MEM_LAT-1]));
      for (int i = 1; i < LATENCY; i++) acc_pipe[i] <= acc_pipe[i-1];
    end
  end
  assign mac_product = acc_pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] val;
    int           vcyc;
  } exp_t;
  exp_t sb[$];

  // Current job timeline, read by the per-cycle checker.
  bit           j_act  = 1'b0;
  int           j_s    = 0;
  int           j_len  = 0;
  int           j_kill = 32'h7fff_ffff;
  logic [W-1:0] j_bias = '0;

  // 0: ready high, 1: random ready, 2: ready low
  int rdy_mode = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = ($urandom_range(0, 3) != 0);
        default: result_ready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control-output checker: addr / mac_ce / mac_load / mac_zero every cycle
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      int t, k, op, c_end;
      logic e_ce, e_load, e_zero;
      logic [ADDR_W-1:0] e_addr;
      t      = cyc;
      k      = t - j_s - 1;
      op     = k - MEM_LAT;
      c_end  = j_s + 1 + j_len + MEM_LAT + LATENCY;
      e_addr = (j_act && k >= 0 && k <= j_len) ? ADDR_W'(k) : '0;
      e_ce   = j_act && t >= j_s + 1 && t <= c_end;
      e_zero = e_ce && !(op >= 0 && op <= j_len);
      e_load = j_act && (t == j_s + 1 + MEM_LAT);
      if (t >= j_kill) begin
        e_addr = '0;
        e_ce   = 1'b0;
        e_zero = 1'b0;
        e_load = 1'b0;
      end
      check("ctrl{ce,load,zero,addr}", 64'({mac_ce, mac_load, mac_zero, addr}),
            64'({e_ce, e_load, e_zero, e_addr}));
      if (e_load) check("load_data", 64'(mac_load_data), 64'(j_bias));
    end
  end

  // ---------------------------------------------------------------------------
  // Result monitor: pops the scoreboard on each transfer
  // ---------------------------------------------------------------------------
  logic         p_valid = 1'b0;
  logic         p_ready = 1'b0;
  logic [W-1:0] p_result = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        check("hold_valid", 64'(result_valid), 64'(1));
        check("hold_result", 64'(result), 64'(p_result));
      end
      if (p_valid && p_ready) check("valid_drop", 64'(result_valid), 64'(0));
      if (result_valid && !p_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 64'(result_valid), 64'(0));
        else                check("valid_cycle", 64'(cyc), 64'(sb[0].vcyc));
      end
      if (result_valid && result_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.val));
      end
      p_valid  = result_valid;
      p_ready  = result_ready;
      p_result = result;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      data_mem[i] = 16'($urandom);
      coef_mem[i] = 16'($urandom);
    end
  endtask

  function automatic logic [W-1:0] rand_bias();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Issue a job while the DUT is idle; queue its dot product and timeline.
  task automatic issue_job(int l, logic [W-1:0] b);
    logic [W-1:0] exp_v;
    exp_v = b;
    for (int k = 0; k <= l; k++) exp_v += W'(data_mem[k]) * W'(coef_mem[k]);
    start  = 1'b1;
    len    = ADDR_W'(l);
    bias   = b;
    sb.push_back('{exp_v, cyc + l + MEM_LAT + LATENCY + 2});
    j_act  = 1'b1;
    j_s    = cyc;
    j_len  = l;
    j_kill = 32'h7fff_ffff;
    j_bias = b;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: timeout with %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: timeout, result_valid never rose");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    fill_random();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_outputs",
          64'({busy, addr, mac_ce, mac_load, mac_zero, result_valid}), 64'(0));
    check("reset_load_data", 64'(mac_load_data), 64'(0));
    check("reset_result", 64'(result), 64'(0));

    // LEN=3, BIAS=10, data {1,2,3,4}, coef 1 -> 20
    rdy_mode = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_mem[i] = 16'(i + 1);
      coef_mem[i] = 16'd1;
    end
    issue_job(3, 48'd10);
    wait_idle();

    // LEN=0, BIAS=0, data 7, coef 3 -> 21
    data_mem[0] = 16'd7;
    coef_mem[0] = 16'd3;
    issue_job(0, 48'd0);
    wait_idle();

    // Backpressure: ready held low for 5 cycles of valid
    fill_random();
    rdy_mode = 2;
    issue_job(7, rand_bias());
    wait_valid();
    repeat (5) tick();
    rdy_mode = 0;
    wait_idle();
    tick();
    check("idle_after_xfer", 64'(busy), 64'(0));
    fill_random();
    issue_job(3, rand_bias());
    wait_idle();

    // Abort in the fourth cycle of a LEN=3 job; nothing must come out
    for (int i = 0; i < 4; i++) begin
      data_mem[i] = 16'(i + 1);
      coef_mem[i] = 16'd1;
    end
    issue_job(3, 48'd10);
    tick();
    tick();
    abort  = 1'b1;
    j_kill = cyc + 1;
    void'(sb.pop_back());
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_valid", 64'(result_valid), 64'(0));
    repeat (12) tick();
    fill_random();
    issue_job(5, rand_bias());
    wait_idle();

    // Abort together with start in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    len   = ADDR_W'(4);
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", 64'(busy), 64'(0));
    repeat (4) tick();

    // Start pulses during ISSUE, DONE and the handshake cycle are ignored
    fill_random();
    rdy_mode = 2;
    issue_job(5, rand_bias());
    tick();
    start = 1'b1;
    len   = ADDR_W'(9);
    bias  = rand_bias();
    tick();
    start = 1'b0;
    wait_valid();
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy_mode = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_handshake_ignored", 64'(busy), 64'(0));
    repeat (4) tick();

    // Full-depth job: ADDR 0..63, no wrap
    fill_random();
    issue_job(DEPTH - 1, rand_bias());
    wait_idle();

    // Asynchronous reset in the middle of ISSUE
    fill_random();
    issue_job(10, rand_bias());
    tick();
    tick();
    rst_n = 1'b0;
    j_act = 1'b0;
    sb.delete();
    #1;
    check("async_reset_outputs",
          64'({busy, addr, mac_ce, mac_load, mac_zero, result_valid}), 64'(0));
    check("async_reset_result", 64'(result), 64'(0));
    check("async_reset_load_data", 64'(mac_load_data), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 64'(busy), 64'(0));
    issue_job(2, rand_bias());
    wait_idle();

    // Randomized jobs with random backpressure
    rdy_mode = 1;
    for (int j = 0; j < 25; j++) begin
      int l;
      fill_random();
      l = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : int'($urandom_range(0, 12));
      issue_job(l, rand_bias());
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
